csr_pins_in_ctrl: RTL

- Input-pin controller that sits between the raw `pins_in` pads and the CSR file. It replaces the direct pin read-through.
- Synchronises every pin, debounces it on a shared prescaled tick, and detects rising and falling edges under per-pin enables.
- Latches detected edges into a pending register and raises a level interrupt request for the interrupt controller.
- All state is readable and writable through the standard CSR port, using the same CSR op semantics as the other core CSRs.

---
 rtl/decoder_pkg.sv | 42 ++++
 rtl/pin_debounce.sv | 54 +++++
 rtl/csr_pins_in_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared CSR decoder definitions used by the pin-input controller.
// Holds the CSR address/operand types, the CSR op encoding, the pin-input
// register addresses and small helpers for the CSR operand and write-enable.
package decoder_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    // Bit 2 selects the immediate variant; bits 1:0 select RW/RS/RC.
    typedef enum logic [2:0] {
        CSR_NONE = 3'd0,
        CSR_RW   = 3'd1,
        CSR_RS   = 3'd2,
        CSR_RC   = 3'd3,
        CSR_RWI  = 3'd5,
        CSR_RSI  = 3'd6,
        CSR_RCI  = 3'd7
    } csr_op_t;

    localparam int unsigned InWidth = 8;
    typedef logic [InWidth-1:0] InT;

    localparam CsrAddrT InAddr     = 12'h7C0;
    localparam CsrAddrT PendAddr   = 12'h7C1;
    localparam CsrAddrT RiseEnAddr = 12'h7C2;
    localparam CsrAddrT FallEnAddr = 12'h7C3;

    function automatic word csr_src(input csr_op_t op, input r zimm, input word data);
        return op[2] ? {27'b0, zimm} : data;
    endfunction

    // RW always writes; RS/RC only write when the source operand is non-zero.
    function automatic logic csr_has_write(input csr_op_t op, input word src);
        case (op)
            CSR_RW, CSR_RWI:                  return 1'b1;
            CSR_RS, CSR_RSI, CSR_RC, CSR_RCI: return (src != '0);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pin_debounce.sv
// One input pin: 2-flop synchroniser, tick-driven debounce counter and the
// accepted (stable) level, plus single-cycle rise/fall pulses that are high
// in the cycle a new level is accepted.
//   clk, reset      core clock, asynchronous active-low reset
//   tick            shared prescaler tick
//   pin_async       raw asynchronous pin
//   stable          debounced level
//   rise, fall      acceptance pulses for 0->1 / 1->0
module pin_debounce #(
    parameter int unsigned DebounceCount = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin_async,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (DebounceCount > 1) ? $clog2(DebounceCount) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCount - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt;
    logic            accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], pin_async};
    end

    assign accept = tick && (sync_q[1] != stable) && (cnt == CntLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_q[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = accept &&  sync_q[1];
    assign fall = accept && !sync_q[1];

endmodule

// File: rtl/csr_pins_in_ctrl.sv
// Input-pin controller between the raw pads and the CSR file.
// Debounces every pin on a shared prescaled tick, latches enabled edges into
// a pending register and raises a registered level interrupt.
//   clk, reset            core clock, asynchronous active-low reset
//   csr_enable/addr/op    CSR access in flight, address, RW/RS/RC (reg/imm)
//   rs1_zimm, rs1_data    immediate and register source operands
//   pins_in               raw asynchronous pins
//   out                   combinational CSR read data (pre-write value)
//   pins_state            debounced pin levels
//   irq                   registered OR of pending & (rise_en | fall_en)
module csr_pins_in_ctrl
    import decoder_pkg::*;
#(
    parameter int unsigned InWidth       = 8,
    parameter int unsigned PrescaleDiv   = 1000,
    parameter int unsigned DebounceCount = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_enable,
    input  CsrAddrT            csr_addr,
    input  csr_op_t            csr_op,
    input  r                   rs1_zimm,
    input  word                rs1_data,
    input  logic [InWidth-1:0] pins_in,
    output word                out,
    output logic [InWidth-1:0] pins_state,
    output logic               irq
);

    localparam int unsigned PsW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PrescaleDiv - 1);

    logic [PsW-1:0]     ps_cnt;
    logic               tick;
    logic [InWidth-1:0] stable, pending, rise_en, fall_en;
    logic [InWidth-1:0] rise_evt, fall_evt, hw_set;
    logic [InWidth-1:0] cur_val, src_bits, wr_val;
    word                src;
    logic               do_write;

    assign tick = (ps_cnt == PsLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    ps_cnt <= '0;
        else if (tick) ps_cnt <= '0;
        else           ps_cnt <= ps_cnt + 1'b1;
    end

    for (genvar i = 0; i < InWidth; i++) begin : g_pin
        pin_debounce #(
            .DebounceCount(DebounceCount)
        ) u_pin (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .pin_async(pins_in[i]),
            .stable   (stable[i]),
            .rise     (rise_evt[i]),
            .fall     (fall_evt[i])
        );
    end

    assign hw_set = (rise_evt & rise_en) | (fall_evt & fall_en);

    always_comb begin
        cur_val = '0;
        if (csr_enable) begin
            case (csr_addr)
                InAddr:     cur_val = stable;
                PendAddr:   cur_val = pending;
                RiseEnAddr: cur_val = rise_en;
                FallEnAddr: cur_val = fall_en;
                default:    cur_val = '0;
            endcase
        end
    end

    assign src      = csr_src(csr_op, rs1_zimm, rs1_data);
    assign src_bits = InWidth'(src);
    assign do_write = csr_enable && csr_has_write(csr_op, src);

    always_comb begin
        wr_val = cur_val;
        case (csr_op)
            CSR_RW, CSR_RWI: wr_val = src_bits;
            CSR_RS, CSR_RSI: wr_val = cur_val | src_bits;
            CSR_RC, CSR_RCI: wr_val = cur_val & ~src_bits;
            default:         wr_val = cur_val;
        endcase
    end

    // Hardware edge sets are OR-ed after the CSR update so a same-cycle
    // set always wins over a CSR clear or write of that bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            rise_en <= '0;
            fall_en <= '0;
            irq     <= 1'b0;
        end else begin
            if (do_write && csr_addr == PendAddr) pending <= wr_val | hw_set;
            else                                  pending <= pending | hw_set;
            if (do_write && csr_addr == RiseEnAddr) rise_en <= wr_val;
            if (do_write && csr_addr == FallEnAddr) fall_en <= wr_val;
            irq <= |(pending & (rise_en | fall_en));
        end
    end

    assign out        = word'(cur_val);
    assign pins_state = stable;

endmodule
